sram_rd_ctrl: RTL and testbench
===============================

# sram_rd_ctrl

Read-side initiator for one port of the dual-port `multi_sram`. It accepts a burst request (start address, word count), issues single-word reads on the SRAM port, and absorbs the SRAM's one-cycle read latency. Returned words are presented as a valid/ready stream with a last flag and full backpressure. It is the consumer end of the data the write side deposits through the opposite SRAM port, and it is the block that drains cached packets out of the memory.

## Interface
Parameters:
- `DWIDTH`, 32, SRAM data width.
- `AWIDTH`, 15, SRAM address width.
- `LWIDTH`, 8, burst-length field width (words).

Ports:
- `clk_in`  in  1  single clock, shared with the SRAM port it drives.
- `rst_n_in`  in  1  reset, synchronous, active-low.
- `req_valid_in`  in  1  burst request valid.
- `req_ready_out`  out  1  block can accept a request; high exactly in IDLE.
- `req_addr_in`  in  AWIDTH  first word address.
- `req_len_in`  in  LWIDTH  word count; 0 = empty burst.
- `sram_en_out`  out  1  SRAM port enable (one read per asserted cycle).
- `sram_we_out`  out  1  SRAM write enable; constant 0.
- `sram_addr_out`  out  AWIDTH  SRAM read address.
- `sram_d_in`  in  DWIDTH  SRAM read data, valid the cycle after `sram_en_out`.
- `dout_valid_out`  out  1  output word valid.
- `dout_ready_in`  in  1  downstream accepts word.
- `dout_data_out`  out  DWIDTH  output word.
- `dout_last_out`  out  1  final word of the burst, qualified by valid.
- `done_out`  out  1  one-cycle pulse when the burst completes.

## Operation
- FSM states:
  - IDLE: `req_ready_out=1`. Handshake `req_valid_in & req_ready_out` latches the address and the remaining-issue count (`req_len_in`) and the remaining-pop count.
    - If `req_len_in==0`, go to DONE.
    - Otherwise go to RUN.
  - RUN: issue reads while the issue count is nonzero and credit is available. Go to DRAIN when the last read is issued.
  - DRAIN: wait until the last word is popped, then go to DONE.
  - DONE: one cycle, `done_out=1`, then IDLE.
- Credit rule: issue in a cycle only if `fifo_cnt + inflight - pop < 2`.
  - `inflight` = read issued in the previous cycle.
  - `pop` = `dout_valid_out & dout_ready_in`.
  - The output FIFO depth is 2, so it never overflows and there is no bubble under continuous ready.
- Each issue asserts `sram_en_out` with `sram_addr_out` = current address, then increments the address modulo 2^AWIDTH (wrap from 2^AWIDTH-1 to 0 is legal).
- Word arriving on `sram_d_in` the cycle after an issue is pushed into the FIFO unconditionally.
- FIFO head drives `dout_data_out`. `dout_last_out=1` when the head is word `len-1`, tracked as a tag bit stored per entry.
- Simultaneous push and pop with a full FIFO cannot occur because of the credit rule. Push and pop in the same cycle with 1 entry keeps the count at 1.
- `dout_data_out` is held stable while `dout_valid_out & !dout_ready_in`.
- Synchronous reset at any time:
  - state returns to IDLE, FIFO and inflight are cleared, counters are zeroed.
  - in-flight burst is discarded, no `done_out`.
  - SRAM data returned in the first cycle after reset is ignored.

## Timing
- Reset values: `sram_en_out=0`, `sram_we_out=0`, `sram_addr_out=0`, `dout_valid_out=0`, `dout_data_out=0`, `dout_last_out=0`, `done_out=0`, `req_ready_out=1`. No request is accepted while `rst_n_in=0`.
- Request handshake at cycle 0:
  - first `sram_en_out` in cycle 1.
  - data on `sram_d_in` in cycle 2.
  - first `dout_valid_out` in cycle 3.
- With `dout_ready_in` held high, an N-word burst pops at cycles 3..N+2, `done_out` is high in cycle N+3, and `req_ready_out` returns in cycle N+4.
- Empty burst: `done_out` in cycle 1, no SRAM access, no output.
- Throughput: 1 word/cycle sustained. After a ready stall ends, the first pop occurs in the same cycle ready rises.

## Structure
- Shared package `multi_sram_pkg`: state enum (IDLE, RUN, DRAIN, DONE) and localparam `RD_FIFO_DEPTH = 2`. `DWIDTH`/`AWIDTH` defaults match `multi_sram`.
- One sub-module, `sram_rd_fifo`: 2-entry FIFO storing `{last, data}`, with push/pop/count, synchronous active-low reset.
- FSM, counters and credit logic live in `sram_rd_ctrl`.

## Test plan
- Preload SRAM[0x10..0x13] = 0xA0..0xA3; request addr 0x10, len 4, ready always high:
  - `sram_en_out` in cycles 1–4 with addresses 0x10–0x13.
  - dout A0..A3 in cycles 3–6, last on A3.
  - `done_out` in cycle 7.
- Same burst with `dout_ready_in` toggling 1,0,0,1,…:
  - data order A0..A3 is preserved, no duplicates or drops.
  - `sram_en_out` never asserted when `fifo_cnt + inflight - pop` is 2.
- Request addr 0x7FFE, len 4:
  - addresses issued 0x7FFE, 0x7FFF, 0x0000, 0x0001.
  - data matches the preload at those addresses.
- Request with len 0:
  - `done_out` in cycle 1, no `sram_en_out`, no `dout_valid_out`.
  - `req_ready_out` high again in cycle 2.
- Assert `rst_n_in=0` for one cycle mid-burst (after 2 pops of an 8-word burst):
  - all outputs take reset values, no `done_out`.
  - a new request of len 1 then completes normally with correct data.
- `req_valid_in` held high across back-to-back requests:
  - the second request is accepted only in the cycle after DONE.
  - `sram_we_out` stays 0 throughout.

Source files
------------

// File: rtl/multi_sram_pkg.sv
// Shared definitions for the multi_sram read-side controller.
//   rd_state_e       : read controller FSM states
//   RD_FIFO_DEPTH    : output FIFO depth (sized to cover the SRAM read latency)
//   MULTI_SRAM_*     : default widths matching the multi_sram macro
package multi_sram_pkg;

    localparam int unsigned MULTI_SRAM_DWIDTH = 32;
    localparam int unsigned MULTI_SRAM_AWIDTH = 15;

    localparam int unsigned RD_FIFO_DEPTH = 2;
    localparam int unsigned RD_FIFO_PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int unsigned RD_FIFO_CNT_W = $clog2(RD_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } rd_state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// Small output FIFO for the SRAM read controller; each entry holds {last, data}.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears storage too)
//   push_i/data_i : write an entry (caller guarantees not full)
//   pop_i         : drop the head entry (caller guarantees not empty)
//   head_o        : head entry, zero after reset
//   valid_o/cnt_o : non-empty flag and occupancy
module sram_rd_fifo
    import multi_sram_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     valid_o,
    output logic [RD_FIFO_CNT_W-1:0] cnt_o
);

    logic [WIDTH-1:0]         mem_q [RD_FIFO_DEPTH];
    logic [RD_FIFO_PTR_W-1:0] wr_ptr_q;
    logic [RD_FIFO_PTR_W-1:0] rd_ptr_q;
    logic [RD_FIFO_CNT_W-1:0] cnt_q;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + RD_FIFO_PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + RD_FIFO_PTR_W'(1);
            end
            cnt_q <= cnt_q + RD_FIFO_CNT_W'(push_i) - RD_FIFO_CNT_W'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (cnt_q != '0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sram_rd_ctrl.sv
// Burst read initiator for one port of multi_sram.
// Accepts {addr, len}, issues one SRAM read per cycle while output credit allows,
// absorbs the one-cycle read latency in a 2-entry FIFO and streams words out
// with valid/ready, a last flag and a done pulse.
//   clk_in, rst_n_in                    : clock, synchronous active-low reset
//   req_valid_in/req_ready_out          : burst request handshake (ready only in idle)
//   req_addr_in, req_len_in             : first word address, word count (0 = empty)
//   sram_en_out/we_out/addr_out, d_in   : SRAM port (read-only, data one cycle after en)
//   dout_valid_out/ready_in/data_out/last_out : output word stream
//   done_out                            : one-cycle pulse at burst completion
module sram_rd_ctrl
    import multi_sram_pkg::*;
#(
    parameter int unsigned DWIDTH = MULTI_SRAM_DWIDTH,
    parameter int unsigned AWIDTH = MULTI_SRAM_AWIDTH,
    parameter int unsigned LWIDTH = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [AWIDTH-1:0] req_addr_in,
    input  logic [LWIDTH-1:0] req_len_in,
    output logic              sram_en_out,
    output logic              sram_we_out,
    output logic [AWIDTH-1:0] sram_addr_out,
    input  logic [DWIDTH-1:0] sram_d_in,
    output logic              dout_valid_out,
    input  logic              dout_ready_in,
    output logic [DWIDTH-1:0] dout_data_out,
    output logic              dout_last_out,
    output logic              done_out
);

    rd_state_e         state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [LWIDTH-1:0] iss_cnt_q, iss_cnt_d;
    logic [LWIDTH-1:0] pop_cnt_q, pop_cnt_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;

    logic [RD_FIFO_CNT_W-1:0] fifo_cnt;
    logic                     fifo_valid;
    logic [DWIDTH:0]          fifo_head;
    logic                     pop;
    logic                     issue;
    logic [2:0]               occ;

    assign pop = fifo_valid & dout_ready_in;

    // Words already committed to the FIFO after this cycle: held + arriving - leaving.
    // Issuing only below depth guarantees the returning word always has a slot.
    assign occ   = 3'(fifo_cnt) + 3'(infl_q) - 3'(pop);
    assign issue = (state_q == StRun) && (iss_cnt_q != '0) && (occ < 3'(RD_FIFO_DEPTH));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        iss_cnt_d     = iss_cnt_q;
        pop_cnt_d     = pop ? pop_cnt_q - LWIDTH'(1) : pop_cnt_q;
        infl_d        = issue;
        infl_last_d   = issue && (iss_cnt_q == LWIDTH'(1));
        req_ready_out = 1'b0;
        done_out      = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready_out = 1'b1;
                if (req_valid_in) begin
                    addr_d    = req_addr_in;
                    iss_cnt_d = req_len_in;
                    pop_cnt_d = req_len_in;
                    state_d   = (req_len_in == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (issue) begin
                    addr_d    = addr_q + AWIDTH'(1);
                    iss_cnt_d = iss_cnt_q - LWIDTH'(1);
                    if (iss_cnt_q == LWIDTH'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && (pop_cnt_q == LWIDTH'(1))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_out = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            iss_cnt_q   <= '0;
            pop_cnt_q   <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            iss_cnt_q   <= iss_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    // Read data is pushed the cycle after its issue; clearing infl_q on reset
    // discards the word returned right after reset.
    sram_rd_fifo #(
        .WIDTH (DWIDTH + 1)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_n_in),
        .push_i  (infl_q),
        .data_i  ({infl_last_q, sram_d_in}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .valid_o (fifo_valid),
        .cnt_o   (fifo_cnt)
    );

    assign sram_en_out    = issue;
    assign sram_we_out    = 1'b0;
    assign sram_addr_out  = addr_q;
    assign dout_valid_out = fifo_valid;
    assign dout_data_out  = fifo_head[DWIDTH-1:0];
    assign dout_last_out  = fifo_valid & fifo_head[DWIDTH];

endmodule

// File: tb/tb_sram_rd_ctrl.sv
// Directed testbench for sram_rd_ctrl with a behavioural one-cycle-latency SRAM.
module tb_sram_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [14:0] req_addr;
    logic [7:0]  req_len;
    logic        sram_en;
    logic        sram_we;
    logic [14:0] sram_addr;
    logic [31:0] sram_d;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic        dout_last;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:32767];

    logic        tr_en   [40];
    logic        tr_we   [40];
    logic [14:0] tr_addr [40];
    logic        tr_val  [40];
    logic [31:0] tr_data [40];
    logic        tr_last [40];
    logic        tr_done [40];
    logic        tr_rrdy [40];
    logic        tr_rin  [40];

    always #5 clk = ~clk;

    sram_rd_ctrl dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_addr_in    (req_addr),
        .req_len_in     (req_len),
        .sram_en_out    (sram_en),
        .sram_we_out    (sram_we),
        .sram_addr_out  (sram_addr),
        .sram_d_in      (sram_d),
        .dout_valid_out (dout_valid),
        .dout_ready_in  (dout_ready),
        .dout_data_out  (dout_data),
        .dout_last_out  (dout_last),
        .done_out       (done)
    );

    always @(posedge clk) begin
        if (sram_en) sram_d <= mem[sram_addr];
    end

    function automatic logic [31:0] word(input logic [14:0] a);
        if (a >= 15'h10 && a <= 15'h13) return 32'hA0 + 32'(a - 15'h10);
        return 32'hC000_0000 | 32'(a);
    endfunction

    // Runs one request issued in cycle 0 and records every cycle's outputs.
    // Called and returns at posedge+1; ends with a drain period.
    task automatic run_req(input logic [14:0] a, input logic [7:0] l,
                           input logic [39:0] rdy_pat, input logic [39:0] rst_pat,
                           input int hold, input int ncyc);
        req_addr = a;
        req_len  = l;
        for (int c = 0; c < ncyc; c++) begin
            req_valid  = (c < hold);
            dout_ready = rdy_pat[c];
            rst_n      = !rst_pat[c];
            @(negedge clk);
            tr_en[c]   = sram_en;
            tr_we[c]   = sram_we;
            tr_addr[c] = sram_addr;
            tr_val[c]  = dout_valid;
            tr_data[c] = dout_data;
            tr_last[c] = dout_last;
            tr_done[c] = done;
            tr_rrdy[c] = req_ready;
            tr_rin[c]  = dout_ready;
            @(posedge clk);
            #1;
        end
        req_valid  = 1'b0;
        dout_ready = 1'b1;
        rst_n      = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({sram_en, sram_we, sram_addr, dout_valid, dout_data, dout_last, done, req_ready}
            !== {1'b0, 1'b0, 15'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_vals got en=%b we=%b addr=%h v=%b d=%h l=%b done=%b rdy=%b",
                     sram_en, sram_we, sram_addr, dout_valid, dout_data, dout_last, done,
                     req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_burst();
        logic exp_en, exp_val;
        run_req(15'h10, 8'd4, 40'hFF_FFFF_FFFF, 40'h0, 1, 10);
        for (int c = 0; c < 10; c++) begin
            exp_en  = (c >= 1 && c <= 4);
            exp_val = (c >= 3 && c <= 6);
            n_vec++;
            if (tr_en[c] !== exp_en) begin
                n_err++;
                $display("FAIL burst_en c=%0d got=%b exp=%b", c, tr_en[c], exp_en);
            end
            if (exp_en) begin
                n_vec++;
                if (tr_addr[c] !== 15'(15'h10 + c - 1)) begin
                    n_err++;
                    $display("FAIL burst_addr c=%0d got=%h exp=%h", c, tr_addr[c],
                             15'(15'h10 + c - 1));
                end
            end
            n_vec++;
            if (tr_val[c] !== exp_val) begin
                n_err++;
                $display("FAIL burst_valid c=%0d got=%b exp=%b", c, tr_val[c], exp_val);
            end
            if (exp_val) begin
                n_vec++;
                if (tr_data[c] !== 32'hA0 + 32'(c - 3) || tr_last[c] !== (c == 6)) begin
                    n_err++;
                    $display("FAIL burst_data c=%0d got=%h/%b exp=%h/%b", c, tr_data[c],
                             tr_last[c], 32'hA0 + 32'(c - 3), (c == 6));
                end
            end
            n_vec++;
            if (tr_done[c] !== (c == 7) || tr_rrdy[c] !== (c == 0 || c >= 8)) begin
                n_err++;
                $display("FAIL burst_ctl c=%0d got done=%b rdy=%b exp done=%b rdy=%b", c,
                         tr_done[c], tr_rrdy[c], (c == 7), (c == 0 || c >= 8));
            end
        end
    endtask

    task automatic test_backpressure();
        int outst, npop, ndone, done_cyc;
        logic pop;
        outst = 0; npop = 0; ndone = 0; done_cyc = -1;
        run_req(15'h10, 8'd4, 40'h99_9999_9999, 40'h0, 1, 16);
        for (int c = 0; c < 16; c++) begin
            pop = tr_val[c] & tr_rin[c];
            if (tr_en[c]) begin
                n_vec++;
                if (outst - int'(pop) >= 2) begin
                    n_err++;
                    $display("FAIL bp_credit c=%0d got occ=%0d exp <2", c, outst - int'(pop));
                end
            end
            if (pop) begin
                n_vec++;
                if (tr_data[c] !== 32'hA0 + 32'(npop) || tr_last[c] !== (npop == 3)) begin
                    n_err++;
                    $display("FAIL bp_data c=%0d got=%h/%b exp=%h/%b", c, tr_data[c],
                             tr_last[c], 32'hA0 + 32'(npop), (npop == 3));
                end
                npop++;
            end
            if (tr_val[c] && !tr_rin[c] && c + 1 < 16) begin
                n_vec++;
                if (tr_val[c+1] !== 1'b1 || tr_data[c+1] !== tr_data[c]) begin
                    n_err++;
                    $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c + 1, tr_val[c+1],
                             tr_data[c+1], tr_data[c]);
                end
            end
            if (tr_done[c]) begin
                ndone++;
                done_cyc = c;
            end
            outst += int'(tr_en[c]) - int'(pop);
        end
        n_vec++;
        if (npop != 4 || ndone != 1 || done_cyc != 9) begin
            n_err++;
            $display("FAIL bp_totals got pops=%0d dones=%0d at=%0d exp 4/1/9", npop, ndone,
                     done_cyc);
        end
    endtask

    task automatic test_stall();
        int outst;
        logic pop, exp_en, exp_val;
        int idx;
        outst = 0;
        run_req(15'h40, 8'd6, 40'hFF_FFFF_FF00, 40'h0, 1, 18);
        for (int c = 0; c < 18; c++) begin
            pop     = tr_val[c] & tr_rin[c];
            exp_en  = (c == 1 || c == 2 || (c >= 8 && c <= 11));
            exp_val = (c >= 3 && c <= 13);
            n_vec++;
            if (tr_en[c] !== exp_en) begin
                n_err++;
                $display("FAIL stall_en c=%0d got=%b exp=%b", c, tr_en[c], exp_en);
            end
            if (exp_en) begin
                idx = (c <= 2) ? c - 1 : c - 6;
                n_vec++;
                if (tr_addr[c] !== 15'(15'h40 + idx)) begin
                    n_err++;
                    $display("FAIL stall_addr c=%0d got=%h exp=%h", c, tr_addr[c],
                             15'(15'h40 + idx));
                end
            end
            if (tr_en[c]) begin
                n_vec++;
                if (outst - int'(pop) >= 2) begin
                    n_err++;
                    $display("FAIL stall_credit c=%0d got occ=%0d exp <2", c,
                             outst - int'(pop));
                end
            end
            outst += int'(tr_en[c]) - int'(pop);
            n_vec++;
            if (tr_val[c] !== exp_val) begin
                n_err++;
                $display("FAIL stall_valid c=%0d got=%b exp=%b", c, tr_val[c], exp_val);
            end
            if (exp_val) begin
                idx = (c <= 8) ? 0 : c - 8;
                n_vec++;
                if (tr_data[c] !== word(15'(15'h40 + idx)) || tr_last[c] !== (c == 13)) begin
                    n_err++;
                    $display("FAIL stall_data c=%0d got=%h/%b exp=%h/%b", c, tr_data[c],
                             tr_last[c], word(15'(15'h40 + idx)), (c == 13));
                end
            end
            n_vec++;
            if (tr_done[c] !== (c == 14)) begin
                n_err++;
                $display("FAIL stall_done c=%0d got=%b exp=%b", c, tr_done[c], (c == 14));
            end
        end
    endtask

    task automatic test_wrap();
        logic [14:0] ea;
        run_req(15'h7FFE, 8'd4, 40'hFF_FFFF_FFFF, 40'h0, 1, 10);
        for (int c = 1; c <= 4; c++) begin
            ea = 15'(15'h7FFE + c - 1);
            n_vec++;
            if (tr_en[c] !== 1'b1 || tr_addr[c] !== ea) begin
                n_err++;
                $display("FAIL wrap_addr c=%0d got=%b/%h exp=1/%h", c, tr_en[c], tr_addr[c],
                         ea);
            end
            n_vec++;
            if (tr_val[c+2] !== 1'b1 || tr_data[c+2] !== word(ea)
                || tr_last[c+2] !== (c == 4)) begin
                n_err++;
                $display("FAIL wrap_data c=%0d got=%b/%h/%b exp=1/%h/%b", c + 2, tr_val[c+2],
                         tr_data[c+2], tr_last[c+2], word(ea), (c == 4));
            end
        end
        n_vec++;
        if (tr_done[7] !== 1'b1 || tr_en[5] !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_done got done7=%b en5=%b exp 1/0", tr_done[7], tr_en[5]);
        end
    endtask

    task automatic test_empty();
        run_req(15'h10, 8'd0, 40'hFF_FFFF_FFFF, 40'h0, 1, 5);
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (tr_en[c] !== 1'b0 || tr_val[c] !== 1'b0 || tr_done[c] !== (c == 1)
                || tr_rrdy[c] !== (c != 1)) begin
                n_err++;
                $display("FAIL empty c=%0d got en=%b v=%b done=%b rdy=%b exp 0/0/%b/%b", c,
                         tr_en[c], tr_val[c], tr_done[c], tr_rrdy[c], (c == 1), (c != 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        run_req(15'h20, 8'd8, 40'hFF_FFFF_FFFF, 40'h20, 1, 14);
        for (int c = 3; c <= 4; c++) begin
            n_vec++;
            if (tr_val[c] !== 1'b1 || tr_data[c] !== word(15'(15'h20 + c - 3))) begin
                n_err++;
                $display("FAIL rstmid_pop c=%0d got=%b/%h exp=1/%h", c, tr_val[c],
                         tr_data[c], word(15'(15'h20 + c - 3)));
            end
        end
        n_vec++;
        if ({tr_en[6], tr_we[6], tr_addr[6], tr_val[6], tr_data[6], tr_last[6], tr_done[6],
             tr_rrdy[6]} !== {1'b0, 1'b0, 15'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rstmid_vals got en=%b we=%b addr=%h v=%b d=%h l=%b done=%b rdy=%b",
                     tr_en[6], tr_we[6], tr_addr[6], tr_val[6], tr_data[6], tr_last[6],
                     tr_done[6], tr_rrdy[6]);
        end
        for (int c = 0; c < 14; c++) begin
            if (c >= 6 || tr_done[c]) begin
                n_vec++;
                if (tr_done[c] !== 1'b0 || (c >= 6 && (tr_val[c] !== 1'b0 || tr_en[c] !== 1'b0)))
                begin
                    n_err++;
                    $display("FAIL rstmid_quiet c=%0d got done=%b v=%b en=%b exp 0/0/0", c,
                             tr_done[c], tr_val[c], tr_en[c]);
                end
            end
        end
        run_req(15'h11, 8'd1, 40'hFF_FFFF_FFFF, 40'h0, 1, 6);
        n_vec++;
        if (tr_en[1] !== 1'b1 || tr_addr[1] !== 15'h11 || tr_en[2] !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_new_en got en1=%b addr=%h en2=%b exp 1/0011/0", tr_en[1],
                     tr_addr[1], tr_en[2]);
        end
        n_vec++;
        if (tr_val[3] !== 1'b1 || tr_data[3] !== 32'hA1 || tr_last[3] !== 1'b1
            || tr_done[4] !== 1'b1 || tr_rrdy[5] !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_new got v=%b d=%h l=%b done4=%b rdy5=%b exp 1/a1/1/1/1",
                     tr_val[3], tr_data[3], tr_last[3], tr_done[4], tr_rrdy[5]);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_en;
        run_req(15'h10, 8'd2, 40'hFF_FFFF_FFFF, 40'h0, 10, 10);
        for (int c = 0; c < 10; c++) begin
            exp_en = (c == 1 || c == 2 || c == 7 || c == 8);
            n_vec++;
            if (tr_rrdy[c] !== (c == 0 || c == 6) || tr_en[c] !== exp_en
                || tr_we[c] !== 1'b0 || tr_done[c] !== (c == 5)) begin
                n_err++;
                $display("FAIL b2b c=%0d got rdy=%b en=%b we=%b done=%b exp %b/%b/0/%b", c,
                         tr_rrdy[c], tr_en[c], tr_we[c], tr_done[c], (c == 0 || c == 6),
                         exp_en, (c == 5));
            end
        end
        n_vec++;
        if (tr_addr[7] !== 15'h10 || tr_addr[8] !== 15'h11) begin
            n_err++;
            $display("FAIL b2b_addr got %h %h exp 0010 0011", tr_addr[7], tr_addr[8]);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        dout_ready = 1'b0;
        sram_d     = '0;
        for (int i = 0; i < 32768; i++) mem[i] = word(15'(i));
        test_reset();
        test_burst();
        test_backpressure();
        test_stall();
        test_wrap();
        test_empty();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
